// File: rtl/instruction_execute_pkg.sv
// instruction_execute_pkg: opcodes, instruction field layout and FSM states shared by decoder, executor and bench
package instruction_execute_pkg;
  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_ADD  = 4'd1,
    OP_SUB  = 4'd2,
    OP_AND  = 4'd3,
    OP_OR   = 4'd4,
    OP_XOR  = 4'd5,
    OP_SHL  = 4'd6,
    OP_SHR  = 4'd7,
    OP_ADDI = 4'd8,
    OP_LI   = 4'd9,
    OP_MOV  = 4'd10
  } opcode_t;
  typedef enum logic [1:0] {IDLE, EXEC, OUT} state_t;
  typedef struct packed {
    logic [3:0]  opcode;
    logic [2:0]  rd;
    logic [2:0]  rs1;
    logic [2:0]  rs2;
    logic [2:0]  unused;
    logic [15:0] imm16;
  } instr_t;
  function automatic logic writes_rd(logic [3:0] op);
    return op >= OP_ADD && op <= OP_MOV;
  endfunction
  function automatic logic [31:0] encode(logic [3:0] op, logic [2:0] rd, logic [2:0] rs1, logic [2:0] rs2, logic [15:0] imm);
    return {op, rd, rs1, rs2, 3'b000, imm};
  endfunction
endpackage

// File: rtl/execute_alu.sv
// execute_alu: combinational result of one decoded instruction, modulo 2^32
module execute_alu
  import instruction_execute_pkg::*;
(
  input  logic [3:0]  opcode,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [15:0] imm16,
  output logic [31:0] result
);
  always_comb begin
    result = '0;
    case (opcode)
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_SHL:  result = a << b[4:0];
      OP_SHR:  result = a >> b[4:0];
      OP_ADDI: result = a + {{16{imm16[15]}}, imm16};
      OP_LI:   result = {16'h0000, imm16};
      OP_MOV:  result = a;
      default: result = '0;
    endcase
  end
endmodule

// File: rtl/instruction_execute.sv
// instruction_execute: handshaked single-instruction executor with 8x32 register file
module instruction_execute
  import instruction_execute_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        DIR,
  output logic        ack_from,
  input  logic [31:0] data_in,
  output logic        DOR,
  input  logic        ack_to,
  output logic [31:0] data_out
);
  state_t      state;
  instr_t      instr;
  logic [31:0] regs [8];
  logic [31:0] result;
  logic        unused_bits;
  assign unused_bits = ^instr.unused;
  execute_alu u_alu (
    .opcode(instr.opcode),
    .a(regs[instr.rs1]),
    .b(regs[instr.rs2]),
    .imm16(instr.imm16),
    .result(result)
  );
  // r0 is never written, so after reset it reads as zero without a read-side mux
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      instr    <= '0;
      ack_from <= 1'b0;
      DOR      <= 1'b0;
      data_out <= '0;
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else begin
      case (state)
        IDLE: if (DIR) begin
          instr    <= data_in;
          ack_from <= 1'b1;
          state    <= EXEC;
        end
        EXEC: begin
          ack_from <= 1'b0;
          data_out <= result;
          DOR      <= 1'b1;
          state    <= OUT;
          if (writes_rd(instr.opcode) && instr.rd != 3'd0) regs[instr.rd] <= result;
        end
        OUT: if (ack_to) begin
          DOR   <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_instruction_execute.sv
// tb_instruction_execute: directed checks of ALU results, handshake timing and reset behaviour
module tb_instruction_execute;
  import instruction_execute_pkg::*;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        DIR = 1'b0;
  logic        ack_from;
  logic [31:0] data_in = '0;
  logic        DOR;
  logic        ack_to = 1'b0;
  logic [31:0] data_out;
  int tests = 0;
  int fails = 0;

  instruction_execute dut (
    .clk(clk), .reset(reset), .DIR(DIR), .ack_from(ack_from), .data_in(data_in),
    .DOR(DOR), .ack_to(ack_to), .data_out(data_out)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  typedef struct {
    logic [31:0] w;
    logic [31:0] exp;
    string       name;
  } vec_t;

  task automatic run_instr(input logic [31:0] w, output logic [31:0] r);
    int n = 0;
    @(negedge clk); DIR = 1'b1; data_in = w;
    @(negedge clk); DIR = 1'b0;
    while (DOR !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    tests++;
    if (DOR !== 1'b1) begin fails++; $display("FAIL issue_timeout DOR=%b required 1", DOR); end
    r = data_out;
    ack_to = 1'b1;
    @(negedge clk); ack_to = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    tests++; if (DOR !== 1'b0) begin fails++; $display("FAIL reset_dor got %b required 0", DOR); end
    tests++; if (ack_from !== 1'b0) begin fails++; $display("FAIL reset_ack got %b required 0", ack_from); end
    tests++; if (data_out !== 32'h0) begin fails++; $display("FAIL reset_data got %h required 0", data_out); end
    reset = 1'b0;
  endtask

  task automatic test_alu();
    logic [31:0] r;
    vec_t v [18] = '{
      '{encode(OP_LI,   3'd1, 3'd0, 3'd0, 16'h1234), 32'h00001234, "li_r1"},
      '{encode(OP_LI,   3'd2, 3'd0, 3'd0, 16'h0010), 32'h00000010, "li_r2"},
      '{encode(OP_ADD,  3'd3, 3'd1, 3'd2, 16'h0000), 32'h00001244, "add_r3"},
      '{encode(OP_MOV,  3'd7, 3'd3, 3'd0, 16'h0000), 32'h00001244, "mov_r3"},
      '{encode(OP_LI,   3'd1, 3'd0, 3'd0, 16'h0001), 32'h00000001, "li_r1_1"},
      '{encode(OP_SUB,  3'd4, 3'd0, 3'd1, 16'h0000), 32'hFFFFFFFF, "sub_wrap"},
      '{encode(OP_ADDI, 3'd5, 3'd0, 3'd0, 16'h8000), 32'hFFFF8000, "addi_sext"},
      '{encode(OP_LI,   3'd2, 3'd0, 3'd0, 16'h0021), 32'h00000021, "li_r2_21"},
      '{encode(OP_SHL,  3'd6, 3'd1, 3'd2, 16'h0000), 32'h00000002, "shl_mask"},
      '{encode(OP_AND,  3'd7, 3'd4, 3'd5, 16'h0000), 32'hFFFF8000, "and"},
      '{encode(OP_OR,   3'd7, 3'd1, 3'd2, 16'h0000), 32'h00000021, "or"},
      '{encode(OP_XOR,  3'd7, 3'd4, 3'd5, 16'h0000), 32'h00007FFF, "xor"},
      '{encode(OP_ADD,  3'd7, 3'd4, 3'd1, 16'h0000), 32'h00000000, "add_wrap"},
      '{encode(OP_LI,   3'd2, 3'd0, 3'd0, 16'h001F), 32'h0000001F, "li_r2_31"},
      '{encode(OP_SHL,  3'd6, 3'd1, 3'd2, 16'h0000), 32'h80000000, "shl_31"},
      '{encode(OP_SHR,  3'd7, 3'd6, 3'd2, 16'h0000), 32'h00000001, "shr_31"},
      '{encode(OP_ADDI, 3'd5, 3'd5, 3'd0, 16'h0001), 32'hFFFF8001, "addi_pos"},
      '{encode(OP_ADDI, 3'd5, 3'd5, 3'd0, 16'hFFFF), 32'hFFFF8000, "addi_neg"}
    };
    foreach (v[i]) begin
      run_instr(v[i].w, r);
      tests++;
      if (r !== v[i].exp) begin fails++; $display("FAIL alu_%s got %h required %h", v[i].name, r, v[i].exp); end
    end
  endtask

  task automatic test_r0_nop();
    logic [31:0] r;
    run_instr(encode(OP_LI, 3'd0, 3'd0, 3'd0, 16'hFFFF), r);
    run_instr(encode(OP_MOV, 3'd7, 3'd0, 3'd0, 16'h0000), r);
    tests++; if (r !== 32'h0) begin fails++; $display("FAIL r0_read got %h required 0", r); end
    run_instr(encode(4'hF, 3'd3, 3'd1, 3'd1, 16'h1234), r);
    tests++; if (r !== 32'h0) begin fails++; $display("FAIL op15_result got %h required 0", r); end
    run_instr(encode(OP_NOP, 3'd3, 3'd1, 3'd1, 16'h1234), r);
    tests++; if (r !== 32'h0) begin fails++; $display("FAIL nop_result got %h required 0", r); end
    run_instr(encode(OP_MOV, 3'd7, 3'd3, 3'd0, 16'h0000), r);
    tests++; if (r !== 32'h00001244) begin fails++; $display("FAIL nop_no_write got %h required 00001244", r); end
  endtask

  task automatic test_handshake();
    logic [31:0] r;
    @(negedge clk); DIR = 1'b1; data_in = encode(OP_LI, 3'd1, 3'd0, 3'd0, 16'h00AB);
    @(negedge clk);
    tests++; if (ack_from !== 1'b1) begin fails++; $display("FAIL hs_ack_pulse got %b required 1", ack_from); end
    tests++; if (DOR !== 1'b0) begin fails++; $display("FAIL hs_dor_early got %b required 0", DOR); end
    data_in = encode(OP_LI, 3'd2, 3'd0, 3'd0, 16'hBEEF);
    @(negedge clk);
    tests++; if (ack_from !== 1'b0) begin fails++; $display("FAIL hs_ack_clear got %b required 0", ack_from); end
    tests++; if (DOR !== 1'b1) begin fails++; $display("FAIL hs_dor_rise got %b required 1", DOR); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tests++;
      if (DOR !== 1'b1 || ack_from !== 1'b0 || data_out !== 32'h000000AB) begin
        fails++; $display("FAIL hs_hold cycle %0d got DOR=%b ack=%b data=%h required 1 0 000000ab", i, DOR, ack_from, data_out);
      end
    end
    DIR = 1'b0; ack_to = 1'b1;
    @(negedge clk); ack_to = 1'b0;
    tests++; if (DOR !== 1'b0) begin fails++; $display("FAIL hs_dor_fall got %b required 0", DOR); end
    tests++; if (data_out !== 32'h000000AB) begin fails++; $display("FAIL hs_data_retain got %h required 000000ab", data_out); end
    @(negedge clk);
    tests++; if (ack_from !== 1'b0) begin fails++; $display("FAIL hs_ignored_ack got %b required 0", ack_from); end
    run_instr(encode(OP_MOV, 3'd7, 3'd2, 3'd0, 16'h0000), r);
    tests++; if (r !== 32'h0000001F) begin fails++; $display("FAIL hs_ignored_write got %h required 0000001f", r); end
  endtask

  task automatic test_ack_early();
    @(negedge clk); ack_to = 1'b1; DIR = 1'b1; data_in = encode(OP_ADD, 3'd7, 3'd1, 3'd2, 16'h0000);
    @(negedge clk); DIR = 1'b0;
    @(negedge clk);
    tests++; if (DOR !== 1'b1 || data_out !== 32'h000000CA) begin fails++; $display("FAIL early_out got DOR=%b data=%h required 1 000000ca", DOR, data_out); end
    @(negedge clk);
    tests++; if (DOR !== 1'b0) begin fails++; $display("FAIL early_one_cycle got %b required 0", DOR); end
    ack_to = 1'b0;
  endtask

  task automatic test_back_to_back();
    @(negedge clk); ack_to = 1'b1; DIR = 1'b1; data_in = encode(OP_LI, 3'd1, 3'd0, 3'd0, 16'h0005);
    @(negedge clk); data_in = encode(OP_ADDI, 3'd1, 3'd1, 3'd0, 16'h0001);
    @(negedge clk);
    tests++; if (DOR !== 1'b1 || data_out !== 32'h5) begin fails++; $display("FAIL b2b_first got DOR=%b data=%h required 1 00000005", DOR, data_out); end
    @(negedge clk);
    tests++; if (DOR !== 1'b0) begin fails++; $display("FAIL b2b_dor_fall got %b required 0", DOR); end
    @(negedge clk);
    tests++; if (ack_from !== 1'b1) begin fails++; $display("FAIL b2b_recapture got %b required 1", ack_from); end
    data_in = encode(OP_ADDI, 3'd1, 3'd1, 3'd0, 16'h0001);
    @(negedge clk);
    tests++; if (DOR !== 1'b1 || data_out !== 32'h6) begin fails++; $display("FAIL b2b_second got DOR=%b data=%h required 1 00000006", DOR, data_out); end
    repeat (3) @(negedge clk);
    tests++; if (DOR !== 1'b1 || data_out !== 32'h7) begin fails++; $display("FAIL b2b_third got DOR=%b data=%h required 1 00000007", DOR, data_out); end
    DIR = 1'b0;
    @(negedge clk); ack_to = 1'b0;
  endtask

  task automatic test_reset_midflight();
    logic [31:0] r;
    @(negedge clk); DIR = 1'b1; data_in = encode(OP_LI, 3'd3, 3'd0, 3'd0, 16'h0055);
    @(negedge clk); DIR = 1'b0;
    tests++; if (ack_from !== 1'b1) begin fails++; $display("FAIL rst_exec_pre got %b required 1", ack_from); end
    reset = 1'b1;
    @(negedge clk);
    tests++; if (DOR !== 1'b0 || ack_from !== 1'b0 || data_out !== 32'h0) begin fails++; $display("FAIL rst_exec got DOR=%b ack=%b data=%h required 0 0 0", DOR, ack_from, data_out); end
    reset = 1'b0;
    run_instr(encode(OP_MOV, 3'd7, 3'd3, 3'd0, 16'h0000), r);
    tests++; if (r !== 32'h0) begin fails++; $display("FAIL rst_exec_rd got %h required 0", r); end
    @(negedge clk); DIR = 1'b1; data_in = encode(OP_LI, 3'd3, 3'd0, 3'd0, 16'h0077);
    @(negedge clk); DIR = 1'b0;
    @(negedge clk);
    tests++; if (DOR !== 1'b1) begin fails++; $display("FAIL rst_out_pre got %b required 1", DOR); end
    reset = 1'b1; DIR = 1'b1; ack_to = 1'b1;
    @(negedge clk);
    tests++; if (DOR !== 1'b0 || ack_from !== 1'b0 || data_out !== 32'h0) begin fails++; $display("FAIL rst_out got DOR=%b ack=%b data=%h required 0 0 0", DOR, ack_from, data_out); end
    reset = 1'b0; DIR = 1'b0; ack_to = 1'b0;
    run_instr(encode(OP_MOV, 3'd7, 3'd3, 3'd0, 16'h0000), r);
    tests++; if (r !== 32'h0) begin fails++; $display("FAIL rst_out_rd got %h required 0", r); end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_r0_nop();
    test_handshake();
    test_ack_early();
    test_back_to_back();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/instruction_execute.md
INSTRUCTION_EXECUTE -- requirements
Module: instruction_execute

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all logic rising-edge.
REQ-002 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-003 SHALL have port DIR, input, 1, upstream (decoder) data-in ready; data_in valid while high.
REQ-004 SHALL have port ack_from, output, 1, acknowledge to upstream: instruction captured.
REQ-005 SHALL have port data_in, input, 32, decoded instruction word.
REQ-006 SHALL have port DOR, output, 1, data-out ready to downstream.
REQ-007 SHALL have port ack_to, input, 1, downstream acknowledge of data_out.
REQ-008 SHALL have port data_out, output, 32, execution result.

Function
REQ-009 SHALL decode data_in fields: [31:28] opcode, [27:25] rd, [24:22] rs1, [21:19] rs2, [15:0] imm16; bits [18:16] ignored.
REQ-010 SHALL implement opcodes: 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 SHL, 7 SHR (logical), 8 ADDI (rs1 + sign-extended imm16), 9 LI (zero-extended imm16), 10 MOV (rs1).
REQ-011 SHALL hold an 8 x 32-bit register file; r0 reads 0 always, writes to r0 discarded.
REQ-012 SHALL compute all arithmetic modulo 2^32, no carry/overflow flags; shift amount = rs2 value [4:0].
REQ-013 SHALL treat NOP and opcodes 11-15 as result 0, no register write, handshake still completed.
REQ-014 SHALL implement FSM states IDLE, EXEC, OUT.
REQ-015 IDLE: when DIR sampled high, SHALL latch data_in, drive ack_from=1 next cycle, go EXEC; else stay.
REQ-016 EXEC (exactly one cycle): SHALL compute result from latched word, write rd, register data_out, set DOR=1, clear ack_from, go OUT.
REQ-017 ack_from SHALL be a single-cycle pulse per accepted instruction.
REQ-018 OUT: SHALL hold DOR=1 and data_out stable until ack_to sampled high; then clear DOR, go IDLE.
REQ-019 ack_to high already when DOR rises SHALL be accepted at the first OUT edge (DOR high exactly one cycle).
REQ-020 Latency: DIR sampled at edge N -> ack_from high cycle N+1 -> DOR high cycle N+2.
REQ-021 DIR SHALL be ignored outside IDLE; minimum instruction period 3 cycles with immediate ack_to.
REQ-022 Back-to-back dependency (rd of instr k used as rs of k+1) SHALL read the updated value (write completes in EXEC before next capture).
REQ-023 data_out SHALL retain last result after DOR falls until next EXEC.

Reset
REQ-024 reset SHALL force state IDLE, DOR=0, ack_from=0, data_out=0, all registers 0, in any state.
REQ-025 Instruction in flight at reset SHALL be discarded: no register write, no DOR.
REQ-026 reset SHALL override DIR and ack_to in the same cycle.

Structure
REQ-027 Opcode constants, field bit positions and FSM state encodings SHALL reside in a shared package used also by the decoder and bench.
REQ-028 Combinational ALU SHALL be a sub-module named execute_alu (inputs opcode, a, b, imm16; output result 32).
REQ-029 Register file and FSM SHALL reside in instruction_execute; no memory ports.

Verification
REQ-030 LI r1,0x1234 then LI r2,0x0010, ADD r3,r1,r2 -> data_out 0x00001244, r3=0x00001244.
REQ-031 SUB r4,r0,r1 with r1=1 -> data_out 0xFFFFFFFF; ADDI r5,r0,imm 0x8000 -> 0xFFFF8000.
REQ-032 SHL r6,r1,r2 with r1=1, r2=0x21 -> 0x00000002 (amount masked to 1); SHR of 0x80000000 by 31 -> 0x00000001.
REQ-033 DIR at edge N, ack_to held low 5 cycles -> ack_from pulse only at N+1, DOR high N+2..N+7, data_out stable, second DIR ignored.
REQ-034 LI r0,0xFFFF then MOV r7,r0 -> data_out 0; opcode 0xF -> data_out 0, no register change, DOR still asserted.
REQ-035 reset asserted in EXEC and in OUT -> next cycle DOR=0, ack_from=0, data_out=0, target rd unchanged (0).
